// File: rtl/rmt_phv_fifo.sv
// PHV buffer between the last match-action stage and the deparser, first-word-fall-through.
// Latency: a write in cycle N is visible on phv_out in cycle N+1; a pop in cycle N exposes the next entry in cycle N+1.
// Backpressure: there is no ready, so the producer cannot be stalled. nearly_full is a registered early warning toward the parser. Writes into a full FIFO without a same-cycle pop are dropped and flagged.
//
// Ports:
//   clk, srst            : core clock; synchronous active-high reset
//   phv_in, phv_in_valid : write data and single-cycle write strobe
//   phv_out              : head-of-queue PHV
//   phv_out_valid        : queue non-empty
//   phv_rd_en            : pop the head (ignored when phv_out_valid=0)
//   nearly_full, full    : registered status flags
//   occupancy            : registered entry count
//   overflow             : sticky dropped-write flag
//   overflow_cnt         : dropped-write count
// Optional feature macro RMT_PHV_FIFO_OVF_CNT_EN: when defined, overflow_cnt is a saturating
// counter of dropped writes. When it is undefined, overflow_cnt is tied to zero.
module rmt_phv_fifo #(
    parameter int PHV_WIDTH    = 1124,
    parameter int DEPTH        = 32,
    parameter int AFULL_THRESH = 24,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic [PHV_WIDTH-1:0]     phv_in,
    input  logic                     phv_in_valid,
    output logic [PHV_WIDTH-1:0]     phv_out,
    output logic                     phv_out_valid,
    input  logic                     phv_rd_en,
    output logic                     nearly_full,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow,
    output logic [CNT_WIDTH-1:0]     overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_THRESH);

    logic [PHV_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW:0]          occ_next;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 drop;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    // An empty FIFO never pops, even if a write lands in that cycle.
    assign rd_ok = phv_rd_en & phv_out_valid;
    assign wr_ok = phv_in_valid & (~full | rd_ok);
    assign drop  = phv_in_valid & full & ~rd_ok;

    always_comb begin
        occ_next = occupancy + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end

    // Storage has no reset. Stale contents are never visible because phv_out_valid gates them.
    always_ff @(posedge clk) begin
        if (!srst && wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= phv_in;
        end
    end

    assign phv_out = mem[rd_ptr[AW-1:0]];

    // The pointers carry one extra bit. They wrap modulo 2*DEPTH, and only the low bits address the memory.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            phv_out_valid <= 1'b0;
            full          <= 1'b0;
            nearly_full   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr + (AW+1)'(wr_ok);
            rd_ptr        <= rd_ptr + (AW+1)'(rd_ok);
            occupancy     <= occ_next;
            phv_out_valid <= (occ_next != '0);
            full          <= (occ_next == DEPTH_C);
            nearly_full   <= (occ_next >= AFULL_C);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef RMT_PHV_FIFO_OVF_CNT_EN
    logic [CNT_WIDTH-1:0] ovf_cnt;

    // The counter saturates at all-ones so that a long overflow storm never wraps back to a small value.
    always_ff @(posedge clk) begin
        if (srst) begin
            ovf_cnt <= '0;
        end else if (drop && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_WIDTH'(1);
        end
    end

    assign overflow_cnt = ovf_cnt;
`else
    assign overflow_cnt = '0;
`endif

endmodule

// File: tb/tb_rmt_phv_fifo.sv
module tb_rmt_phv_fifo;

    localparam int W     = 48;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          srst;
    logic [W-1:0]  phv_in;
    logic          phv_in_valid;
    logic [W-1:0]  phv_out;
    logic          phv_out_valid;
    logic          phv_rd_en;
    logic          nearly_full;
    logic          full;
    logic [3:0]    occupancy;
    logic          overflow;
    logic [CW-1:0] overflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: a plain queue plus the drop bookkeeping.
    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    int           m_cnt = 0;

    rmt_phv_fifo #(
        .PHV_WIDTH(W), .DEPTH(DEPTH), .AFULL_THRESH(AFULL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .srst(srst),
        .phv_in(phv_in), .phv_in_valid(phv_in_valid),
        .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_rd_en(phv_rd_en),
        .nearly_full(nearly_full), .full(full), .occupancy(occupancy),
        .overflow(overflow), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt();
`ifdef RMT_PHV_FIFO_OVF_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Model update on the same edge the DUT uses.
    always @(posedge clk) begin
        bit rd;
        bit wr;
        if (srst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            rd = phv_rd_en && (mq.size() > 0);
            wr = phv_in_valid && ((mq.size() < DEPTH) || rd);
            if (phv_in_valid && !wr) begin
                m_ovf = 1'b1;
                if (m_cnt != CMAX) m_cnt++;
            end
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back(phv_in);
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("occupancy", 64'(occupancy), 64'(mq.size()));
            check("phv_out_valid", 64'(phv_out_valid), 64'(mq.size() > 0));
            check("full", 64'(full), 64'(mq.size() == DEPTH));
            check("nearly_full", 64'(nearly_full), 64'(mq.size() >= AFULL));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("overflow_cnt", 64'(overflow_cnt), 64'(exp_cnt()));
            if (mq.size() > 0) check("phv_out", 64'(phv_out), 64'(mq[0]));
        end
    end

    // Apply one cycle of stimulus. Called at a negedge, it returns at the next negedge.
    task automatic drive(input bit v, input logic [W-1:0] d, input bit rd);
        phv_in_valid = v;
        phv_in       = d;
        phv_rd_en    = rd;
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd_phv();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    int nwr;
    bit v;
    bit rd;

    initial begin
        srst = 1'b1; phv_in_valid = 1'b0; phv_in = '0; phv_rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_valid", 64'(phv_out_valid), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        srst = 1'b0;

        // Three writes, no pops.
        drive(1, 48'h1, 0);
        check("first_valid", 64'(phv_out_valid), 64'd1);
        check("first_out", 64'(phv_out), 64'h1);
        drive(1, 48'h2, 0);
        drive(1, 48'h3, 0);
        check("three_occ", 64'(occupancy), 64'd3);
        check("three_head", 64'(phv_out), 64'h1);

        // Three back-to-back pops, then a pop while empty.
        drive(0, '0, 1);
        check("pop1_out", 64'(phv_out), 64'h2);
        drive(0, '0, 1);
        check("pop2_out", 64'(phv_out), 64'h3);
        drive(0, '0, 1);
        check("pop3_valid", 64'(phv_out_valid), 64'd0);
        check("pop3_occ", 64'(occupancy), 64'd0);
        drive(0, '0, 1);
        check("empty_pop_occ", 64'(occupancy), 64'd0);

        // Fill to the nearly-full threshold, then to full.
        for (int i = 0; i < 6; i++) drive(1, 48'h10 + 48'(i), 0);
        check("afull_nf", 64'(nearly_full), 64'd1);
        check("afull_full", 64'(full), 64'd0);
        drive(1, 48'h16, 0);
        drive(1, 48'h17, 0);
        check("full_flag", 64'(full), 64'd1);
        check("full_occ", 64'(occupancy), 64'd8);

        // A write and a pop in the same cycle while full, then two dropped writes.
        drive(1, 48'h77, 1);
        check("fullrw_occ", 64'(occupancy), 64'd8);
        check("fullrw_ovf", 64'(overflow), 64'd0);
        drive(1, 48'h88, 0);
        drive(1, 48'h99, 0);
        check("drop_ovf", 64'(overflow), 64'd1);
`ifdef RMT_PHV_FIFO_OVF_CNT_EN
        check("drop_cnt", 64'(overflow_cnt), 64'd2);
`else
        check("drop_cnt", 64'(overflow_cnt), 64'd0);
`endif
        // Drain the queue. The model checks the order of the outgoing PHVs.
        for (int i = 0; i < DEPTH; i++) drive(0, '0, 1);
        check("drain_occ", 64'(occupancy), 64'd0);

        // Wrap-around: 3*DEPTH+5 writes with about 50% pops, keeping occupancy below DEPTH.
        nwr = 0;
        for (int c = 0; c < 2000 && nwr < 3*DEPTH+5; c++) begin
            v  = ($urandom_range(0, 1) == 1) && (mq.size() < DEPTH-1);
            rd = ($urandom_range(0, 1) == 1);
            if (v) nwr++;
            drive(v, rnd_phv(), rd);
        end
        check("wrap_writes", 64'(nwr), 64'(3*DEPTH+5));
        for (int i = 0; i < DEPTH; i++) drive(0, '0, 1);
        check("wrap_drain_occ", 64'(occupancy), 64'd0);

        // Random phase biased toward filling, which exercises drops and saturation.
        for (int c = 0; c < 300; c++) drive($urandom_range(0, 3) != 0, rnd_phv(), $urandom_range(0, 2) == 0);
        for (int c = 0; c < 150; c++) drive($urandom_range(0, 1) == 1, rnd_phv(), $urandom_range(0, 3) != 0);

        // Reset in the middle of operation with occupancy 5. The write in the reset cycle is ignored.
        for (int i = 0; i < DEPTH; i++) drive(0, '0, 1);
        for (int i = 0; i < 5; i++) drive(1, 48'h50 + 48'(i), 0);
        check("pre_rst_occ", 64'(occupancy), 64'd5);
        srst = 1'b1;
        drive(1, 48'hDEAD, 1);
        srst = 1'b0;
        check("mid_rst_occ", 64'(occupancy), 64'd0);
        check("mid_rst_valid", 64'(phv_out_valid), 64'd0);
        check("mid_rst_ovf", 64'(overflow), 64'd0);
        drive(1, 48'hA, 0);
        check("post_rst_out", 64'(phv_out), 64'hA);
        check("post_rst_occ", 64'(occupancy), 64'd1);
        drive(0, '0, 1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
